// File: rtl/wb_slave_mem.sv
// Wishbone B3 slave RAM with programmable wait states, CTI/BTE bursts and out-of-window error response.
// Optional macro WB_MEM_RAND_WAIT_EN adds LFSR-driven random wait states and inter-beat gaps.
module wb_slave_mem #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] s_wb_adr_i,
    input  logic [3:0]  s_wb_sel_i,
    input  logic        s_wb_we_i,
    input  logic [31:0] s_wb_dat_i,
    output logic [31:0] s_wb_dat_o,
    input  logic        s_wb_cyc_i,
    input  logic        s_wb_stb_i,
    input  logic [2:0]  s_wb_cti_i,
    input  logic [1:0]  s_wb_bte_i,
    output logic        s_wb_ack_o,
    output logic        s_wb_err_o,
    output logic [7:0]  err_cnt_o
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [31:0] WINDOW = 32'(DEPTH * 4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER} state_e;

    state_e      state_q, state_d;
    logic [4:0]  waitCnt_q, waitCnt_d, loadVal;
    logic [31:0] adr_q, adr_d, nextAdr, issueAdr, issueOff;
    logic        we_q, we_d;
    logic [2:0]  cti_q, cti_d;
    logic [1:0]  bte_q, bte_d;
    logic        ack_q, ack_d, err_q, err_d;
    logic [31:0] dat_q;
    logic [7:0]  errCnt_q, errCnt_d;
    logic [AW-1:0] beatIdx_q, issueIdx;
    logic        issue, issueInRange, burst, beatDone, commit, gap;
    logic [31:0] mem [DEPTH];

`ifdef WB_MEM_RAND_WAIT_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    assign loadVal = 5'(WAIT_STATES) + {3'b000, lfsr_q[1:0]};
    assign gap     = lfsr_q[0];
`else
    assign loadVal = 5'(WAIT_STATES);
    assign gap     = 1'b0;
`endif

    assign burst        = (cti_q == 3'b001) || (cti_q == 3'b010);
    assign beatDone     = ack_q & s_wb_stb_i & s_wb_cyc_i;
    assign issueOff     = issueAdr - BASE_ADDR;
    assign issueInRange = issueOff < WINDOW;
    assign issueIdx     = issueOff[AW+1:2];

    // Wrap bursts only advance the low word-address bits; constant bursts stay put.
    always_comb begin
        nextAdr = adr_q;
        if (cti_q == 3'b010) begin
            case (bte_q)
                2'b00:   nextAdr = adr_q + 32'd4;
                2'b01:   nextAdr[3:2] = adr_q[3:2] + 2'd1;
                2'b10:   nextAdr[4:2] = adr_q[4:2] + 3'd1;
                default: nextAdr[5:2] = adr_q[5:2] + 4'd1;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        adr_d     = adr_q;
        we_d      = we_q;
        cti_d     = cti_q;
        bte_d     = bte_q;
        issue     = 1'b0;
        issueAdr  = adr_q;
        if (!s_wb_cyc_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (s_wb_stb_i) begin
                        adr_d    = s_wb_adr_i;
                        we_d     = s_wb_we_i;
                        cti_d    = s_wb_cti_i;
                        bte_d    = s_wb_bte_i;
                        issueAdr = s_wb_adr_i;
                        if (loadVal == 5'd0) begin
                            issue   = 1'b1;
                            state_d = S_XFER;
                        end else begin
                            waitCnt_d = loadVal;
                            state_d   = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (s_wb_stb_i) begin
                        if (waitCnt_q <= 5'd1) begin
                            issue   = 1'b1;
                            state_d = S_XFER;
                        end else begin
                            waitCnt_d = waitCnt_q - 5'd1;
                        end
                    end
                end
                S_XFER: begin
                    // A completed beat prefetches the next word; a stalled burst re-issues the held address.
                    if (err_q || !burst) begin
                        state_d = S_IDLE;
                    end else if (ack_q && s_wb_stb_i) begin
                        if (s_wb_cti_i == 3'b111) begin
                            state_d = S_IDLE;
                        end else begin
                            adr_d    = nextAdr;
                            issueAdr = nextAdr;
                            issue    = !gap;
                        end
                    end else if (s_wb_stb_i) begin
                        issue = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ack_d    = issue & issueInRange;
        err_d    = issue & !issueInRange;
        commit   = beatDone & we_q;
        errCnt_d = errCnt_q;
        if (err_d && errCnt_q != 8'hFF) begin
            errCnt_d = errCnt_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q   <= S_IDLE;
            waitCnt_q <= '0;
            adr_q     <= '0;
            we_q      <= 1'b0;
            cti_q     <= '0;
            bte_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            errCnt_q  <= '0;
            beatIdx_q <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            adr_q     <= adr_d;
            we_q      <= we_d;
            cti_q     <= cti_d;
            bte_q     <= bte_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            errCnt_q  <= errCnt_d;
            if (issue) begin
                beatIdx_q <= issueIdx;
                dat_q     <= issueInRange ? mem[issueIdx] : '0;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (s_wb_sel_i[b]) begin
                    mem[beatIdx_q][8*b +: 8] <= s_wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign s_wb_ack_o = ack_q;
    assign s_wb_err_o = err_q;
    assign s_wb_dat_o = dat_q;
    assign err_cnt_o  = errCnt_q;
endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem: classic transaction table plus burst, abort and saturation sequences.
module tb_wb_slave_mem;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned WS    = 1;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] adr, wdat, datO;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack, err;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [7:0]  errCnt;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic        expErr;
        logic [31:0] expDat;
        logic [7:0]  expErrCnt;
    } vec_t;

    vec_t        vecs[$];
    int          vecCount  = 0;
    int          missCount = 0;
    logic [31:0] wrBuf [16];
    logic [31:0] rdBuf [16];

    always #5 clk = ~clk;

    wb_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rstN),
        .s_wb_adr_i (adr),
        .s_wb_sel_i (sel),
        .s_wb_we_i  (we),
        .s_wb_dat_i (wdat),
        .s_wb_dat_o (datO),
        .s_wb_cyc_i (cyc),
        .s_wb_stb_i (stb),
        .s_wb_cti_i (cti),
        .s_wb_bte_i (bte),
        .s_wb_ack_o (ack),
        .s_wb_err_o (err),
        .err_cnt_o  (errCnt)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic w, input logic [31:0] a, input logic [3:0] s,
                                   input logic [31:0] d, input logic e, input logic [31:0] x,
                                   input logic [7:0] c);
        vec_t v;
        v.we = w; v.adr = a; v.sel = s; v.wdat = d;
        v.expErr = e; v.expDat = x; v.expErrCnt = c;
        return v;
    endfunction

    function automatic void addVec(input logic w, input logic [31:0] a, input logic [3:0] s,
                                   input logic [31:0] d, input logic e, input logic [31:0] x,
                                   input logic [7:0] c);
        vecs.push_back(mkVec(w, a, s, d, e, x, c));
    endfunction

    // One classic cycle; lat is the cycle count from request sample to ack/err, -1 on timeout.
    task automatic classicCycle(input logic [31:0] a, input logic w, input logic [3:0] s,
                                input logic [31:0] d, output logic gotAck, output logic gotErr,
                                output logic [31:0] gotDat, output int lat, output logic tail);
        int cycles;
        cycles = 0;
        gotAck = 1'b0; gotErr = 1'b0; gotDat = '0; lat = -1;
        @(posedge clk); #1;
        adr = a; we = w; sel = s; wdat = d; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
        while (lat < 0 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            if (ack || err) begin
                gotAck = ack; gotErr = err; gotDat = datO; lat = cycles;
            end
        end
        @(posedge clk); #1;
        tail = ack | err;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        logic gAck, gErr, tail;
        logic [31:0] gDat;
        int lat;
        classicCycle(v.adr, v.we, v.sel, v.wdat, gAck, gErr, gDat, lat, tail);
        checkOutput($sformatf("v%0d.latency", idx), 32'(lat), 32'(WS + 1));
        checkOutput($sformatf("v%0d.ack", idx), 32'(gAck), 32'(!v.expErr));
        checkOutput($sformatf("v%0d.err", idx), 32'(gErr), 32'(v.expErr));
        checkOutput($sformatf("v%0d.oneCycle", idx), 32'(tail), 32'd0);
        if (!v.we || v.expErr) begin
            checkOutput($sformatf("v%0d.dat", idx), gDat, v.expErr ? 32'd0 : v.expDat);
        end
        checkOutput($sformatf("v%0d.errCnt", idx), 32'(errCnt), 32'(v.expErrCnt));
    endtask

    // Registered-feedback burst master; optional stb gap after gapAfter completed beats.
    task automatic burstXfer(input logic [31:0] startAdr, input logic w, input logic [1:0] b,
                             input int nBeats, input int gapAfter, input int gapLen,
                             output int beats, output logic sawErr, output int lastCycle);
        int   cycles, gapLeft;
        logic stbNow;
        beats = 0; sawErr = 1'b0; lastCycle = -1; cycles = 0; gapLeft = 0;
        @(posedge clk); #1;
        adr = startAdr; we = w; bte = b; sel = 4'hF; wdat = wrBuf[0];
        cti = (nBeats == 1) ? 3'b111 : 3'b010; cyc = 1'b1; stb = 1'b1;
        while (beats < nBeats && !sawErr && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
            if (gapLeft == 1) checkOutput("burst.gapAck", 32'(ack), 32'd0);
            stbNow = (gapLeft == 0);
            if (gapLeft > 0) gapLeft--;
            stb  = stbNow;
            wdat = wrBuf[beats];
            cti  = (beats == nBeats - 1) ? 3'b111 : 3'b010;
            if (stbNow && err) begin
                rdBuf[beats] = datO; sawErr = 1'b1; lastCycle = cycles;
            end else if (stbNow && ack) begin
                rdBuf[beats] = datO; beats++; lastCycle = cycles;
                if (beats == gapAfter) gapLeft = gapLen;
            end
        end
        @(posedge clk); #1;
        checkOutput("burst.endIdle", 32'({ack, err}), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    endtask

    initial begin
        int   beats, lastCycle;
        logic sawErr, gAck, gErr, tail;
        logic [31:0] gDat;
        int   lat;

        rstN = 1'b0; adr = '0; wdat = '0; sel = '0; we = 1'b0;
        cyc = 1'b0; stb = 1'b0; cti = '0; bte = '0;

        addVec(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0,         8'd0);
        addVec(1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF, 8'd0);
        addVec(1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 1'b0, 32'h0,         8'd0);
        addVec(1'b1, 32'h0000_0020, 4'b0101, 32'hAABB_CCDD, 1'b0, 32'h0,      8'd0);
        addVec(1'b0, 32'h0000_0020, 4'hF, 32'h0,         1'b0, 32'h11BB_33DD, 8'd0);
        addVec(1'b1, 32'h0000_0120, 4'hF, 32'h5A5A_5A5A, 1'b0, 32'h0,         8'd0);
        addVec(1'b1, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0,         8'd0);
        addVec(1'b1, 32'h0000_0040, 4'hF, 32'h4040_4040, 1'b0, 32'h0,         8'd0);
        addVec(1'b1, 32'h0000_0030, 4'hF, 32'hC0DE_0030, 1'b0, 32'h0,         8'd0);
        addVec(1'b1, 32'h0000_0034, 4'hF, 32'hC0DE_0034, 1'b0, 32'h0,         8'd0);
        addVec(1'b1, 32'h0000_0038, 4'hF, 32'hC0DE_0038, 1'b0, 32'h0,         8'd0);
        addVec(1'b1, 32'h0000_003C, 4'hF, 32'hC0DE_003C, 1'b0, 32'h0,         8'd0);
        addVec(1'b1, 32'h0000_0FF8, 4'hF, 32'hF8F8_F8F8, 1'b0, 32'h0,         8'd0);
        addVec(1'b1, 32'h0000_0FFC, 4'hF, 32'hFCFC_FCFC, 1'b0, 32'h0,         8'd0);
        addVec(1'b0, 32'h0000_0FFC, 4'hF, 32'h0,         1'b0, 32'hFCFC_FCFC, 8'd0);
        addVec(1'b0, 32'h0000_1000, 4'hF, 32'h0,         1'b1, 32'h0,         8'd1);
        addVec(1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0,         8'd2);
        addVec(1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b0, 32'h0BAD_F00D, 8'd2);
        addVec(1'b0, 32'h0000_0013, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF, 8'd2);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.ack",    32'(ack),    32'd0);
        checkOutput("reset.err",    32'(err),    32'd0);
        checkOutput("reset.dat",    datO,        32'd0);
        checkOutput("reset.errCnt", 32'(errCnt), 32'd0);
        rstN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i, vecs[i]);
        end

        $display("[TB] wrap4 read burst from 0x38");
        burstXfer(32'h0000_0038, 1'b0, 2'b01, 4, -1, 0, beats, sawErr, lastCycle);
        checkOutput("wrap4.beats", 32'(beats), 32'd4);
        checkOutput("wrap4.lastCycle", 32'(lastCycle), 32'd5);
        checkOutput("wrap4.d0", rdBuf[0], 32'hC0DE_0038);
        checkOutput("wrap4.d1", rdBuf[1], 32'hC0DE_003C);
        checkOutput("wrap4.d2", rdBuf[2], 32'hC0DE_0030);
        checkOutput("wrap4.d3", rdBuf[3], 32'hC0DE_0034);

        $display("[TB] linear write burst of 8 from 0x100 with stb gap");
        for (int i = 0; i < 16; i++) wrBuf[i] = 32'hB0B0_0000 | 32'(i);
        burstXfer(32'h0000_0100, 1'b1, 2'b00, 8, 3, 2, beats, sawErr, lastCycle);
        checkOutput("lin.beats", 32'(beats), 32'd8);
        checkOutput("lin.lastCycle", 32'(lastCycle), 32'd12);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(100 + i, mkVec(1'b0, 32'h100 + 32'(4 * i), 4'hF, 32'h0, 1'b0,
                                         32'hB0B0_0000 | 32'(i), 8'd2));
        end
        applyStimulus(108, mkVec(1'b0, 32'h0000_0120, 4'hF, 32'h0, 1'b0, 32'h5A5A_5A5A, 8'd2));

        $display("[TB] linear read burst running off the top of the window");
        burstXfer(32'h0000_0FF8, 1'b0, 2'b00, 3, -1, 0, beats, sawErr, lastCycle);
        checkOutput("top.beats", 32'(beats), 32'd2);
        checkOutput("top.sawErr", 32'(sawErr), 32'd1);
        checkOutput("top.errCycle", 32'(lastCycle), 32'd4);
        checkOutput("top.d0", rdBuf[0], 32'hF8F8_F8F8);
        checkOutput("top.d1", rdBuf[1], 32'hFCFC_FCFC);
        checkOutput("top.errDat", rdBuf[2], 32'd0);
        checkOutput("top.errCnt", 32'(errCnt), 32'd3);

        $display("[TB] cyc dropped during wait phase");
        @(posedge clk); #1;
        adr = 32'h0000_0040; we = 1'b1; sel = 4'hF; wdat = 32'hBAD0_0040;
        cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        checkOutput("cycDrop.wait", 32'({ack, err}), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("cycDrop.idle", 32'({ack, err}), 32'd0);
        end
        we = 1'b0;
        applyStimulus(200, mkVec(1'b0, 32'h0000_0040, 4'hF, 32'h0, 1'b0, 32'h4040_4040, 8'd3));

        $display("[TB] reset asserted during wait phase");
        @(posedge clk); #1;
        adr = 32'h0000_0040; we = 1'b1; sel = 4'hF; wdat = 32'hBAD1_0040;
        cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        rstN = 1'b0;
        #1;
        checkOutput("rstAbort.ack",    32'(ack),    32'd0);
        checkOutput("rstAbort.err",    32'(err),    32'd0);
        checkOutput("rstAbort.dat",    datO,        32'd0);
        checkOutput("rstAbort.errCnt", 32'(errCnt), 32'd0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        applyStimulus(201, mkVec(1'b0, 32'h0000_0040, 4'hF, 32'h0, 1'b0, 32'h4040_4040, 8'd0));

        $display("[TB] error counter saturation");
        for (int i = 0; i < 260; i++) begin
            classicCycle(32'h0000_2000, 1'b0, 4'hF, 32'h0, gAck, gErr, gDat, lat, tail);
        end
        checkOutput("errCnt.saturate", 32'(errCnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
